// File: rtl/heap_pkg.sv
// Action codes, error codes and FSM state type shared by the heap controller.
package heap_pkg;

  localparam logic [7:0] HEAP_NOP   = 8'd0;
  localparam logic [7:0] HEAP_ALLOC = 8'd1;
  localparam logic [7:0] HEAP_FREE  = 8'd2;
  localparam logic [7:0] HEAP_READ  = 8'd3;
  localparam logic [7:0] HEAP_WRITE = 8'd4;
  localparam logic [7:0] HEAP_PUSH  = 8'd5;
  localparam logic [7:0] HEAP_POP   = 8'd6;
  localparam logic [7:0] HEAP_SIZE  = 8'd7;

  localparam logic [7:0] HEAP_OK          = 8'd0;
  localparam logic [7:0] HEAP_ERR_UNALLOC = 8'd1;
  localparam logic [7:0] HEAP_ERR_INDEX   = 8'd2;
  localparam logic [7:0] HEAP_ERR_FULL    = 8'd3;
  localparam logic [7:0] HEAP_ERR_EMPTY   = 8'd4;
  localparam logic [7:0] HEAP_ERR_ACTION  = 8'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } heapState_t;

endpackage

// File: rtl/heap_controller_if.sv
// Requester-side bus of the heap controller: per-requester request/operand lanes plus shared result.
interface heap_controller_if #(
  parameter int unsigned NREQ   = 2,
  parameter int unsigned ARRAYS = 4,
  parameter int unsigned SLOTS  = 8,
  parameter int unsigned DW     = 12
);
  localparam int unsigned AW = $clog2(ARRAYS);
  localparam int unsigned IW = $clog2(SLOTS);

  logic [NREQ-1:0]    req;
  logic [NREQ*8-1:0]  action;
  logic [NREQ*AW-1:0] array;
  logic [NREQ*IW-1:0] index;
  logic [NREQ*DW-1:0] data_in;
  logic [NREQ-1:0]    done;
  logic [DW-1:0]      data_out;
  logic [7:0]         error;
  logic               busy;

  modport master (
    output req, action, array, index, data_in,
    input  done, data_out, error, busy
  );

  modport slave (
    input  req, action, array, index, data_in,
    output done, data_out, error, busy
  );
endinterface

// File: rtl/heap_controller_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at the pointer and wraps.
module rr_arbiter #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   pointer,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   winner,
  output logic            any
);

  // First requester at or after the pointer wins.
  always_comb begin
    grant  = '0;
    winner = '0;
    any    = 1'b0;
    for (int k = 0; k < int'(NREQ); k++) begin
      if (!any && req[(int'(pointer) + k) % int'(NREQ)]) begin
        any = 1'b1;
        grant[(int'(pointer) + k) % int'(NREQ)] = 1'b1;
        winner = PW'((int'(pointer) + k) % int'(NREQ));
      end
    end
  end

endmodule

// File: rtl/heap_controller.sv
// Heap storage with array actions, shared by NREQ requesters through a round-robin arbiter.
module heap_controller
  import heap_pkg::*;
#(
  parameter int unsigned NREQ   = 2,
  parameter int unsigned ARRAYS = 4,
  parameter int unsigned SLOTS  = 8,
  parameter int unsigned DW     = 12
) (
  input logic              clock,
  input logic              reset,
  heap_controller_if.slave bus
);

  localparam int unsigned AW = $clog2(ARRAYS);
  localparam int unsigned IW = $clog2(SLOTS);
  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  heapState_t state, stateNext;

  logic [PW-1:0]   rrPtr, rrPtrNext, winner, curReq;
  logic [NREQ-1:0] grant, curGrant;
  logic            anyReq, latchOps, commit;

  logic            busy, busyNext;
  logic [NREQ-1:0] done, doneNext;
  logic [DW-1:0]   dataOut, dataNext;
  logic [7:0]      error, errorNext;

  logic [7:0]    curAction;
  logic [AW-1:0] curArray;
  logic [IW-1:0] curIndex;
  logic [DW-1:0] curData;
  logic [DW-1:0] resData;
  logic [7:0]    resError;

  logic [IW:0]       sizeReg [ARRAYS];
  logic [ARRAYS-1:0] allocated;
  logic [DW-1:0]     mem [ARRAYS][SLOTS];

  logic [IW:0]   curSize, sizeNew;
  logic [IW-1:0] memIdx, popIdx;
  logic [7:0]    execErr;
  logic [DW-1:0] execData;
  logic          memWe, sizeWe, allocWe, allocNew;

  rr_arbiter #(.NREQ(NREQ), .PW(PW)) uArb (
    .req     (bus.req),
    .pointer (rrPtr),
    .grant   (grant),
    .winner  (winner),
    .any     (anyReq)
  );

  // Action decode: error check in priority order, then storage side effects and result.
  always_comb begin
    curSize  = sizeReg[curArray];
    popIdx   = curSize[IW-1:0] - IW'(1);
    execErr  = HEAP_OK;
    execData = '0;
    memWe    = 1'b0;
    memIdx   = curIndex;
    sizeWe   = 1'b0;
    sizeNew  = curSize;
    allocWe  = 1'b0;
    allocNew = 1'b0;
    if (curAction > HEAP_SIZE) begin
      execErr = HEAP_ERR_ACTION;
    end else if (curAction != HEAP_NOP && curAction != HEAP_ALLOC && !allocated[curArray]) begin
      execErr = HEAP_ERR_UNALLOC;
    end else if ((curAction == HEAP_READ || curAction == HEAP_WRITE) && {1'b0, curIndex} >= curSize) begin
      execErr = HEAP_ERR_INDEX;
    end else if (curAction == HEAP_PUSH && curSize == (IW+1)'(SLOTS)) begin
      execErr = HEAP_ERR_FULL;
    end else if (curAction == HEAP_POP && curSize == '0) begin
      execErr = HEAP_ERR_EMPTY;
    end else begin
      case (curAction)
        HEAP_ALLOC: begin
          allocWe  = 1'b1;
          allocNew = 1'b1;
          sizeWe   = 1'b1;
          sizeNew  = '0;
          execData = DW'(curArray);
        end
        HEAP_FREE: begin
          allocWe = 1'b1;
          sizeWe  = 1'b1;
          sizeNew = '0;
        end
        HEAP_READ:  execData = mem[curArray][curIndex];
        HEAP_WRITE: memWe = 1'b1;
        HEAP_PUSH: begin
          memWe   = 1'b1;
          memIdx  = curSize[IW-1:0];
          sizeWe  = 1'b1;
          sizeNew = curSize + (IW+1)'(1);
        end
        HEAP_POP: begin
          sizeWe   = 1'b1;
          sizeNew  = curSize - (IW+1)'(1);
          execData = mem[curArray][popIdx];
        end
        HEAP_SIZE:  execData = DW'(curSize);
        default: ;
      endcase
    end
  end

  // FSM next state and next values of the registered outputs.
  always_comb begin
    stateNext = state;
    busyNext  = busy;
    doneNext  = '0;
    dataNext  = dataOut;
    errorNext = error;
    rrPtrNext = rrPtr;
    latchOps  = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        busyNext = anyReq;
        if (anyReq) begin
          latchOps  = 1'b1;
          stateNext = EXEC;
        end
      end
      EXEC: begin
        busyNext  = 1'b1;
        commit    = 1'b1;
        stateNext = RESP;
      end
      RESP: begin
        busyNext  = 1'b1;
        doneNext  = curGrant;
        dataNext  = resData;
        errorNext = resError;
        rrPtrNext = (curReq == PW'(NREQ - 1)) ? '0 : curReq + PW'(1);
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  // Outputs, operand latch, pointer and array bookkeeping.
  always_ff @(posedge clock) begin
    if (reset) begin
      rrPtr     <= '0;
      busy      <= 1'b0;
      done      <= '0;
      dataOut   <= '0;
      error     <= '0;
      curReq    <= '0;
      curGrant  <= '0;
      curAction <= '0;
      curArray  <= '0;
      curIndex  <= '0;
      curData   <= '0;
      resData   <= '0;
      resError  <= '0;
      allocated <= '0;
      for (int a = 0; a < int'(ARRAYS); a++) sizeReg[a] <= '0;
    end else begin
      rrPtr   <= rrPtrNext;
      busy    <= busyNext;
      done    <= doneNext;
      dataOut <= dataNext;
      error   <= errorNext;
      if (latchOps) begin
        curReq    <= winner;
        curGrant  <= grant;
        curAction <= bus.action[int'(winner)*8 +: 8];
        curArray  <= bus.array[int'(winner)*int'(AW) +: AW];
        curIndex  <= bus.index[int'(winner)*int'(IW) +: IW];
        curData   <= bus.data_in[int'(winner)*int'(DW) +: DW];
      end
      if (commit) begin
        resData  <= execData;
        resError <= execErr;
        if (sizeWe)  sizeReg[curArray]   <= sizeNew;
        if (allocWe) allocated[curArray] <= allocNew;
      end
    end
  end

  // Element storage; a reset on the commit edge drops the pending write.
  always_ff @(posedge clock) begin
    if (!reset && commit && memWe) mem[curArray][memIdx] <= curData;
  end

  assign bus.done     = done;
  assign bus.data_out = dataOut;
  assign bus.error    = error;
  assign bus.busy     = busy;

endmodule

// File: tb/tb_heap_controller.sv
// Directed bench for heap_controller: latency, actions, error priority, arbitration, reset abort.
module tb_heap_controller;
  import heap_pkg::*;

  localparam int unsigned NREQ = 2;
  localparam int unsigned ARRAYS = 4;
  localparam int unsigned SLOTS = 8;
  localparam int unsigned DW = 12;
  localparam int unsigned AW = 2;
  localparam int unsigned IW = 3;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  heap_controller_if #(.NREQ(NREQ), .ARRAYS(ARRAYS), .SLOTS(SLOTS), .DW(DW)) bus ();

  heap_controller #(.NREQ(NREQ), .ARRAYS(ARRAYS), .SLOTS(SLOTS), .DW(DW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Issue one action on requester r and wait (bounded) for its done pulse.
  task automatic doAction(input int r, input int act, input int arr, input int idx, input int din,
                          output logic [DW-1:0] dOut, output logic [7:0] err,
                          output int lat, output int busyCnt);
    bus.req[r] = 1'b1;
    bus.action[r*8 +: 8] = 8'(act);
    bus.array[r*AW +: AW] = AW'(arr);
    bus.index[r*IW +: IW] = IW'(idx);
    bus.data_in[r*DW +: DW] = DW'(din);
    lat = 0;
    busyCnt = 0;
    dOut = '0;
    err = '0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clock);
      if (bus.busy) busyCnt++;
      if (bus.done[r]) begin
        lat = c;
        dOut = bus.data_out;
        err = bus.error;
        break;
      end
    end
    bus.req[r] = 1'b0;
  endtask

  // One action with expected result, error code and 3-cycle latency.
  task automatic run(input string tag, input int r, input int act, input int arr, input int idx,
                     input int din, input int expData, input int expErr);
    logic [DW-1:0] d;
    logic [7:0] e;
    int lat, bc;
    doAction(r, act, arr, idx, din, d, e, lat, bc);
    checkEq({tag, "_lat"}, lat, 3);
    checkEq({tag, "_data"}, d, expData);
    checkEq({tag, "_err"}, e, expErr);
  endtask

  initial begin
    logic [DW-1:0] d;
    logic [7:0] e;
    int lat, bc, n, last;
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.req = '0;
    bus.action = '0;
    bus.array = '0;
    bus.index = '0;
    bus.data_in = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;

    checkEq("rst_done", bus.done, 0);
    checkEq("rst_busy", bus.busy, 0);
    checkEq("rst_data", bus.data_out, 0);
    checkEq("rst_err", bus.error, 0);

    // First ALLOC: latency and busy window.
    doAction(0, 1, 1, 0, 0, d, e, lat, bc);
    checkEq("alloc1_lat", lat, 3);
    checkEq("alloc1_data", d, 1);
    checkEq("alloc1_err", e, 0);
    checkEq("alloc1_busycnt", bc, 3);
    @(negedge clock);
    checkEq("alloc1_busy_after", bus.busy, 0);
    checkEq("alloc1_done_after", bus.done, 0);

    // Push/pop/size sequence on array 1.
    run("push3", 0, 5, 1, 0, 3, 0, 0);
    run("push2", 0, 5, 1, 0, 2, 0, 0);
    run("size2", 0, 7, 1, 0, 0, 2, 0);
    run("pop2", 0, 6, 1, 0, 0, 2, 0);
    run("size1", 0, 7, 1, 0, 0, 1, 0);

    // Error codes.
    run("read_unalloc", 0, 3, 2, 0, 0, 0, 1);
    run("write_oob", 0, 4, 1, 5, 12'h555, 0, 2);
    run("read_i0", 0, 3, 1, 0, 0, 3, 0);
    run("bad_action", 0, 9, 1, 0, 0, 0, 5);
    run("nop", 0, 0, 2, 0, 0, 0, 0);
    run("write_i0", 0, 4, 1, 0, 12'h0AB, 0, 0);
    run("read_i0_new", 0, 3, 1, 0, 0, 12'h0AB, 0);

    // Fill array 0, overflow, then underflow on a fresh array.
    run("alloc0", 0, 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 8; k++) run("fill", 0, 5, 0, 0, 100 + k, 0, 0);
    run("push_full", 0, 5, 0, 0, 999, 0, 3);
    run("size_full", 0, 7, 0, 0, 0, 8, 0);
    run("read_i7", 0, 3, 0, 7, 0, 107, 0);
    run("pop_full", 0, 6, 0, 0, 0, 107, 0);
    run("alloc3", 0, 1, 3, 0, 0, 3, 0);
    run("pop_empty", 0, 6, 3, 0, 0, 0, 4);
    run("free0_r1", 1, 2, 0, 0, 0, 0, 0);
    run("size_freed_r1", 1, 7, 0, 0, 0, 0, 1);

    // Both requesters hold SIZE on array 1: grants alternate 0,1,... three cycles apart.
    bus.action = {8'(HEAP_SIZE), 8'(HEAP_SIZE)};
    bus.array = {AW'(1), AW'(1)};
    bus.index = '0;
    bus.req = 2'b11;
    n = 0;
    last = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clock);
      if (bus.done != '0) begin
        checkEq("rr_grant", bus.done, (n % 2 == 0) ? 1 : 2);
        checkEq("rr_data", bus.data_out, 1);
        if (n > 0) checkEq("rr_spacing", c - last, 3);
        last = c;
        n++;
        if (n == 10) break;
      end
    end
    bus.req = '0;
    checkEq("rr_count", n, 10);

    // Reset during EXEC of a PUSH abandons it and clears bookkeeping.
    run("alloc2", 0, 1, 2, 0, 0, 2, 0);
    bus.req[0] = 1'b1;
    bus.action[7:0] = HEAP_PUSH;
    bus.array[AW-1:0] = AW'(2);
    bus.data_in[DW-1:0] = DW'(55);
    @(negedge clock);
    checkEq("abort_busy_exec", bus.busy, 1);
    reset = 1'b1;
    bus.req = '0;
    @(negedge clock);
    checkEq("abort_busy", bus.busy, 0);
    checkEq("abort_done", bus.done, 0);
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      checkEq("abort_no_done", bus.done, 0);
    end
    run("abort_size_unalloc", 0, 7, 2, 0, 0, 0, 1);
    run("abort_a1_unalloc", 0, 7, 1, 0, 0, 0, 1);
    run("abort_realloc", 0, 1, 2, 0, 0, 2, 0);
    run("abort_size0", 0, 7, 2, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/heap_controller.md
Name: heap_controller

Overview:
- Owns the heap storage used by generated test programs and performs array actions on it: alloc, free, read, write, push, pop and size.
- Serialises access from NREQ independent requesters, e.g. the instruction engine plus a debug/dump port, through a round-robin arbiter.
- Exactly one action executes at a time, with a fixed latency per action.
- Every action returns a data word and an error code.

Parameters:
- NREQ, 2, number of requesters.
- ARRAYS, 4, number of arrays in the heap.
- SLOTS, 8, elements per array.
- DW, 12, element width in bits.
- AW, $clog2(ARRAYS), array-number width (derived, not overridden).
- IW, $clog2(SLOTS), index width (derived, not overridden).

Ports:
- clock  in  1  system clock, rising edge only.
- reset  in  1  synchronous, active-high.
- req  in  NREQ  per-requester request; held high with operands stable until that requester's done.
- action  in  NREQ*8  per-requester action code (heap_pkg).
- array  in  NREQ*AW  per-requester array number.
- index  in  NREQ*IW  per-requester element index.
- data_in  in  NREQ*DW  per-requester write/push data.
- done  out  NREQ  one-cycle completion pulse to the served requester.
- data_out  out  DW  result; valid while any done bit is high.
- error  out  8  error code; valid while any done bit is high.
- busy  out  1  high from grant until the done cycle inclusive.

Behaviour:
- Interface: reset is synchronous, active-high; clock is `clock`.
- Reset values:
  - done=0, data_out=0, error=0, busy=0.
  - State=IDLE; round-robin pointer=0.
  - All size registers 0; all allocated flags 0.
  - Memory contents are not reset.
- FSM has three states, IDLE -> EXEC -> RESP -> IDLE:
  - IDLE: if any req is high, pick winner w (round-robin from pointer), latch w's operands, set busy, go EXEC. Otherwise stay.
  - EXEC:
    - Check errors.
    - On success, perform the size/flag update and the memory write, or issue the memory read.
    - Go RESP.
  - RESP:
    - done[w]=1; drive data_out/error.
    - Pointer becomes (w+1) mod NREQ.
    - busy stays 1 this cycle; go IDLE.
- Latency: req seen at IDLE edge E0 -> done high in the cycle following edge E2. Throughput is one action per 3 cycles.
- Requester rules:
  - A requester must see done before changing operands.
  - Dropping req before done is illegal; the action still completes.
  - done is a single pulse.
- Action codes:
  - 0 NOP: out=0, err=0.
  - 1 ALLOC: allocated=1, size=0; out=array.
  - 2 FREE: allocated=0, size=0.
  - 3 READ: out=mem[a][i].
  - 4 WRITE: mem[a][i]=in.
  - 5 PUSH: mem[a][size]=in; size++.
  - 6POP: size--; out=mem[a][size-1].
  - 7 SIZE: out=size, zero-extended.
- Error codes, checked in this priority order:
  - 5: action > 7.
  - 1: array not allocated (every action except NOP/ALLOC).
  - 2: index >= size on READ/WRITE.
  - 3: PUSH with size==SLOTS.
  - 4: POP with size==0.
- On error: no storage or size change, out=0.
- ALLOC on an already-allocated array re-initialises it (size=0, no error).
- Boundary conditions:
  - size is IW+1 bits wide and saturates by error, never wraps.
  - Requests arriving during EXEC/RESP wait.
  - Simultaneous reqs are granted in pointer order.
  - A requester holding req continuously is served at most every NREQ*3 cycles while others are pending.
- Reset mid-operation: the action is abandoned, no done is issued, and storage writes not yet committed are lost.

Decomposition:
- heap_pkg holds:
  - action code localparams: HEAP_NOP .. HEAP_SIZE;
  - error code localparams: HEAP_OK, HEAP_ERR_UNALLOC, HEAP_ERR_INDEX, HEAP_ERR_FULL, HEAP_ERR_EMPTY, HEAP_ERR_ACTION;
  - the state enum typedef.
- One sub-module, rr_arbiter(NREQ):
  - inputs: req vector, pointer;
  - outputs: one-hot grant, encoded winner, any.
  - Purely combinational; the pointer register lives in heap_controller.

Test Plan:
- Reset, then req0 ALLOC a=1 -> done[0] on the 3rd cycle, error=0, data_out=1, busy high for 3 cycles.
- req0: PUSH a=1 in=3, PUSH in=2, SIZE, POP -> SIZE gives out=2; POP gives out=2, err=0; then SIZE gives 1.
- READ a=2 (unallocated) -> error=1, out=0. WRITE a=1 i=5 when size=1 -> error=2, memory unchanged (read i=0 still 3). Action 9 -> error=5.
- PUSH 8 values into a=0, then a 9th -> 9th error=3, size stays 8. POP on an empty array -> error=4.
- req0 and req1 both held high with SIZE -> grants alternate 0,1,0,1; done cycles spaced 3 apart; no starvation over 10 actions.
- Assert reset during EXEC of a PUSH -> no done, busy=0 next cycle, size=0, allocated cleared.
